// File: rtl/nanci_pkg.sv
// Shared types and helpers for the Nanci shearsort sequencer.
// This package holds the FSM state encoding and the parameter-derived width functions.
package nanci_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } nanci_state_e;

    // Shearsort needs log2(side)+1 row phases interleaved with log2(side) column phases.
    function automatic int nanci_num_phases(input int log_sqrt_n);
        return 2 * log_sqrt_n + 1;
    endfunction

    // Counter width for a modulus n. The result is never zero, so degenerate sizes still get a 1-bit register.
    function automatic int nanci_cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/nanci_step_cnt.sv
// Nested cycle/step counter for one shearsort phase.
// It raises exch on the last PE-latency cycle and step_wrap on the last step of the phase.
module nanci_step_cnt
    import nanci_pkg::*;
#(
    parameter int SQRT_N      = 4,
    parameter int SORT_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic hold,
    output logic odd,
    output logic exch,
    output logic step_wrap
);

    localparam int CYC_W  = nanci_cnt_w(SORT_CYCLES);
    localparam int STEP_W = nanci_cnt_w(SQRT_N);
    localparam logic [CYC_W-1:0]  CYC_LAST  = CYC_W'(SORT_CYCLES - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(SQRT_N - 1);
    localparam logic [CYC_W-1:0]  CYC_ONE   = CYC_W'(1);
    localparam logic [STEP_W-1:0] STEP_ONE  = STEP_W'(1);

    logic [CYC_W-1:0]  cyc_r;
    logic [STEP_W-1:0] step_r;

    // Strobe decode: a held cycle never commits an exchange.
    always_comb begin
        exch      = 1'b0;
        step_wrap = 1'b0;
        if (en && !hold && (cyc_r == CYC_LAST)) begin
            exch      = 1'b1;
            step_wrap = (step_r == STEP_LAST);
        end else begin
            exch      = 1'b0;
            step_wrap = 1'b0;
        end
    end

    assign odd = step_r[0];

    // Counter registers. The clr input acts as a synchronous clear issued from LOAD.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cyc_r  <= {CYC_W{1'b0}};
            step_r <= {STEP_W{1'b0}};
        end else if (clr) begin
            cyc_r  <= {CYC_W{1'b0}};
            step_r <= {STEP_W{1'b0}};
        end else if (exch) begin
            cyc_r  <= {CYC_W{1'b0}};
            step_r <= step_wrap ? {STEP_W{1'b0}} : (step_r + STEP_ONE);
        end else if (en && !hold) begin
            cyc_r  <= cyc_r + CYC_ONE;
        end else begin
            cyc_r  <= cyc_r;
            step_r <= step_r;
        end
    end

endmodule

// File: rtl/nanci_sort_sched.sv
// Global shearsort sequencer: one load strobe, then alternating snake-row and column phases, then a done pulse.
// The phase counter and FSM live here. The step counter and exchange timing live in nanci_step_cnt.
module nanci_sort_sched
    import nanci_pkg::*;
#(
    parameter int SQRT_N      = 4,
    parameter int LOG_SQRT_N  = 2,
    parameter int SORT_CYCLES = 1,
    parameter int NUM_PHASES  = nanci_num_phases(LOG_SQRT_N)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              i_start,
    input  logic                              i_hold,
    output logic                              o_load,
    output logic                              o_exch,
    output logic                              o_row_mode,
    output logic                              o_odd,
    output logic [$clog2(NUM_PHASES+1)-1:0]   o_phase,
    output logic                              o_busy,
    output logic                              o_done
);

    localparam int PHASE_W = $clog2(NUM_PHASES + 1);
    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(NUM_PHASES - 1);
    localparam logic [PHASE_W-1:0] PHASE_ONE  = PHASE_W'(1);
    localparam bit SINGLE_PE = (SQRT_N == 1);

    nanci_state_e      state_r, state_s;
    logic [PHASE_W-1:0] phase_r;
    logic               odd_s, exch_s, step_wrap_s;

    nanci_step_cnt #(
        .SQRT_N      (SQRT_N),
        .SORT_CYCLES (SORT_CYCLES)
    ) u_step_cnt (
        .clk       (clk),
        .rst       (rst),
        .clr       (state_r == LOAD),
        .en        (state_r == RUN),
        .hold      (i_hold),
        .odd       (odd_s),
        .exch      (exch_s),
        .step_wrap (step_wrap_s)
    );

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (i_start) state_s = LOAD;
                else         state_s = IDLE;
            end
            LOAD: begin
                if (SINGLE_PE) state_s = DONE;
                else           state_s = RUN;
            end
            RUN: begin
                if (step_wrap_s && (phase_r == PHASE_LAST)) state_s = DONE;
                else                                         state_s = RUN;
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_r <= IDLE;
        else      state_r <= state_s;
    end

    // Phase counter. It advances once per completed step sweep.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_r <= {PHASE_W{1'b0}};
        end else if (state_r == LOAD) begin
            phase_r <= {PHASE_W{1'b0}};
        end else if (step_wrap_s) begin
            phase_r <= phase_r + PHASE_ONE;
        end else begin
            phase_r <= phase_r;
        end
    end

    // Output decode. Mode and parity outputs are qualified by RUN so that the idle and done states present all zeros.
    always_comb begin
        o_load     = (state_r == LOAD);
        o_busy     = (state_r == LOAD) || (state_r == RUN);
        o_done     = (state_r == DONE);
        o_exch     = exch_s;
        o_row_mode = 1'b0;
        o_odd      = 1'b0;
        o_phase    = {PHASE_W{1'b0}};
        if (state_r == RUN) begin
            o_row_mode = ~phase_r[0];
            o_odd      = odd_s;
            o_phase    = phase_r;
        end else begin
            o_row_mode = 1'b0;
            o_odd      = 1'b0;
            o_phase    = {PHASE_W{1'b0}};
        end
    end

endmodule
